itrx_aib_phy_tx_lane_redn: RTL and testbench
============================================

// Module: itrx_aib_phy_tx_lane_redn
// PURPOSE
//  Parametrised multi-lane AIB TX datapath front end, upstream of the per-bump IO buffers.
//  Registers NLANE logical DDR/SDR lanes onto NLANE+1 physical lanes and remaps them
//  around one failing lane by shifting onto a spare. A sequencer drains and settles
//  around every repair-map change. Also generates PRBS7 and clock training patterns.
// PARAMETERS
//  NLANE   20  logical lanes, 1..63; physical lanes = NLANE+1 (spare is index NLANE)
//  QUIET   8   drain and settle length in cycles, 1..255
//  LANE_W  localparam = $clog2(NLANE+1), width of redn_lane
// PORTS
//  ilaunch_clk  in   1        TX launch clock; the only clock
//  tx_irstb     in   1        reset, synchronous, active-low
//  iddr_enable  in   1        1=DDR (idat0/idat1 distinct), 0=SDR (idat0 only)
//  idat0        in   NLANE    logical lane data, first half-cycle
//  idat1        in   NLANE    logical lane data, second half-cycle
//  pat_mode     in   2        00 normal, 01 PRBS7, 10 clock pattern, 11 force zero
//  redn_req     in   1        one-cycle request to load a new repair map
//  redn_en      in   1        with redn_req: 1=repair lane redn_lane, 0=clear repair
//  redn_lane    in   LANE_W   failing physical lane index
//  odat0        out  NLANE+1  physical lane data to IO buffer idat0
//  odat1        out  NLANE+1  physical lane data to IO buffer idat1
//  otxen        out  NLANE+1  per physical lane TX driver enable
//  oredn_engage out  NLANE+1  per physical lane redundancy-engaged flag
//  redn_busy    out  1        sequencer not IDLE
//  redn_ack     out  1        one-cycle pulse: request completed or rejected
//  redn_err     out  1        valid with redn_ack: request rejected
// BEHAVIOUR
//  Reset (tx_irstb=0 at a clock edge)
//   - All outputs go to 0. Map is cleared, FSM goes to IDLE, PRBS is seeded to 7'h7F.
//   - Reset mid-sequence aborts the sequence and no ack is issued.
//  Datapath, 1-cycle latency
//   - Inputs are registered at ilaunch_clk; a change on idat appears on odat at the next edge.
//   - SDR: odat1 = odat0 = idat0 (mapped).
//  Map with repair off
//   - Physical p<NLANE carries logical p, otxen=1, oredn_engage=0.
//   - Spare lane: otxen=0, data 0.
//  Map with repair on, failing lane f
//   - p<f carries logical p.
//   - p>f carries logical p-1, oredn_engage[p]=1.
//   - Lane f: otxen=0, data 0, oredn_engage=1.
//   - Spare: otxen=1.
//  Patterns, applied before the map (every logical lane)
//   - PRBS7: x^7+x^6+1, shared generator. Even lanes get the true bit, odd lanes the inverted bit.
//   - DDR advances 2 bits per cycle (older bit on odat0). SDR advances 1 bit per cycle.
//   - Entering 01 from any other mode reseeds to 7'h7F on that edge.
//   - Clock pattern: DDR odat0=1, odat1=0 every cycle. SDR toggles 1/0 per cycle starting at 1.
//   - 11: all data 0; otxen still follows the map.
//   - A pat_mode change takes effect at the next edge.
//  Repair FSM (IDLE -> DRAIN -> SWITCH -> SETTLE -> IDLE)
//   - IDLE: on redn_req, if redn_en=1 and redn_lane>=NLANE, stay IDLE and pulse redn_ack with
//     redn_err=1 on the next cycle. Otherwise capture redn_en/redn_lane and go to DRAIN.
//   - DRAIN: QUIET cycles, old map, all data forced 0, otxen unchanged.
//   - SWITCH: 1 cycle; the new map loads at the end of this cycle.
//   - SETTLE: QUIET cycles, new map, all data forced 0.
//   - On exit from SETTLE, redn_ack=1 and redn_err=0 for one cycle; normal data resumes next cycle.
//   - redn_busy=1 in DRAIN, SWITCH and SETTLE.
//   - redn_req while busy is ignored (no ack, no queueing).
//   - A request equal to the current map still runs the full sequence.
//  Counter: 8-bit down-counter, loads QUIET-1, transitions at 0. No wrap.
// TESTING
//  T1: reset, NLANE=20, pat 00, DDR, idat0=20'hA5A5A, idat1=~idat0
//      -> next cycle odat0[19:0]=A5A5A, odat1=~, odat0[20]=0, otxen=21'h0FFFFF.
//  T2: redn_req, redn_en=1, lane 5
//      -> busy for 8+1+8 cycles, zeros throughout; then ack.
//      -> odat0[4:0]=logical[4:0], odat0[20:6]=logical[19:5], otxen[5]=0, otxen[20]=1,
//         oredn_engage=21'h1FFFE0.
//  T3: redn_lane=20 with redn_en=1 -> ack+err the next cycle, map unchanged, busy never 1.
//      redn_req during DRAIN -> ignored.
//  T4: pat 01, DDR, from reset
//      -> lane0 stream over the first 127 bits equals the reference PRBS7 (seed 7F);
//         lane1 carries the inverse; SDR run repeats at a 127-cycle period.
//  T5: tx_irstb low mid-SETTLE -> outputs 0 next edge, map cleared, no ack;
//      a new request after reset completes normally.
//  T6: pat 10 in DDR -> odat0=all 1, odat1=all 0 on enabled lanes; failed lane and disabled spare stay 0.

Source files
------------

// File: rtl/itrx_aib_phy_tx_lane_redn.sv
// AIB TX lane front end: registers NLANE logical lanes onto NLANE+1 physical lanes,
// steers around one failed lane onto the spare, and generates PRBS7 / clock patterns.
module itrx_aib_phy_tx_lane_redn #(
  parameter  int NLANE  = 20,
  parameter  int QUIET  = 8,
  localparam int LANE_W = $clog2(NLANE + 1)
) (
  input  logic              ilaunch_clk,
  input  logic              tx_irstb,
  input  logic              iddr_enable,
  input  logic [NLANE-1:0]  idat0,
  input  logic [NLANE-1:0]  idat1,
  input  logic [1:0]        pat_mode,
  input  logic              redn_req,
  input  logic              redn_en,
  input  logic [LANE_W-1:0] redn_lane,
  output logic [NLANE:0]    odat0,
  output logic [NLANE:0]    odat1,
  output logic [NLANE:0]    otxen,
  output logic [NLANE:0]    oredn_engage,
  output logic              redn_busy,
  output logic              redn_ack,
  output logic              redn_err
);

  localparam logic [7:0] CNT_INIT   = 8'(QUIET - 1);
  localparam logic [6:0] PRBS_SEED  = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_SWITCH = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_en_q, req_en_d;
  logic [LANE_W-1:0]   req_lane_q, req_lane_d;
  logic                map_en_q, map_en_d;
  logic [LANE_W-1:0]   map_lane_q, map_lane_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [6:0]          prbs_q, prbs_d;
  logic [1:0]          pat_q, pat_d;
  logic                clk_tgl_q, clk_tgl_d;
  logic [NLANE:0]      odat0_q, odat0_d;
  logic [NLANE:0]      odat1_q, odat1_d;
  logic [NLANE:0]      otxen_q, otxen_d;
  logic [NLANE:0]      eng_q, eng_d;

  logic [6:0]          prbs_cur, prbs_s1;
  logic                bit0, bit1, clk_bit;
  logic [NLANE-1:0]    log0, log1;
  logic [NLANE:0]      ext0, ext1, sh0, sh1;

  // x^7 + x^6 + 1, output taken from bit 6
  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  always_comb begin : fsm_comb
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_en_d   = req_en_q;
    req_lane_d = req_lane_q;
    map_en_d   = map_en_q;
    map_lane_d = map_lane_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redn_req) begin
          if (redn_en && (redn_lane >= LANE_W'(NLANE))) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            req_en_d   = redn_en;
            req_lane_d = redn_lane;
            cnt_d      = CNT_INIT;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == 8'd0) state_d = S_SWITCH;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_SWITCH: begin
        map_en_d   = req_en_q;
        map_lane_d = req_lane_q;
        cnt_d      = CNT_INIT;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : dp_comb
    pat_d    = pat_mode;
    prbs_cur = ((pat_mode == 2'b01) && (pat_q != 2'b01)) ? PRBS_SEED : prbs_q;
    prbs_s1  = prbs_step(prbs_cur);
    bit0     = prbs_cur[6];
    bit1     = iddr_enable ? prbs_s1[6] : prbs_cur[6];
    prbs_d   = prbs_q;
    if (pat_mode == 2'b01) prbs_d = iddr_enable ? prbs_step(prbs_s1) : prbs_s1;

    // clk_tgl_q holds the last SDR clock-pattern bit; cleared so each run starts at 1
    clk_bit   = ~clk_tgl_q;
    clk_tgl_d = 1'b0;
    if ((pat_mode == 2'b10) && !iddr_enable) clk_tgl_d = clk_bit;

    log0 = '0;
    log1 = '0;
    case (pat_mode)
      2'b00: begin
        log0 = idat0;
        log1 = iddr_enable ? idat1 : idat0;
      end
      2'b01: begin
        for (int i = 0; i < NLANE; i++) begin
          log0[i] = bit0 ^ i[0];
          log1[i] = bit1 ^ i[0];
        end
      end
      2'b10: begin
        if (iddr_enable) begin
          log0 = '1;
          log1 = '0;
        end else begin
          log0 = {NLANE{clk_bit}};
          log1 = {NLANE{clk_bit}};
        end
      end
      default: ;
    endcase
    if (state_q != S_IDLE) begin
      log0 = '0;
      log1 = '0;
    end

    ext0 = {1'b0, log0};
    ext1 = {1'b0, log1};
    sh0  = {log0, 1'b0};
    sh1  = {log1, 1'b0};

    // Steering uses the next map so the new map is visible on the cycle after SWITCH
    odat0_d = '0;
    odat1_d = '0;
    otxen_d = '0;
    eng_d   = '0;
    for (int p = 0; p <= NLANE; p++) begin
      if (!map_en_d) begin
        odat0_d[p] = ext0[p];
        odat1_d[p] = ext1[p];
        otxen_d[p] = (p < NLANE);
        eng_d[p]   = 1'b0;
      end else if (p < int'(map_lane_d)) begin
        odat0_d[p] = ext0[p];
        odat1_d[p] = ext1[p];
        otxen_d[p] = 1'b1;
        eng_d[p]   = 1'b0;
      end else if (p == int'(map_lane_d)) begin
        odat0_d[p] = 1'b0;
        odat1_d[p] = 1'b0;
        otxen_d[p] = 1'b0;
        eng_d[p]   = 1'b1;
      end else begin
        odat0_d[p] = sh0[p];
        odat1_d[p] = sh1[p];
        otxen_d[p] = 1'b1;
        eng_d[p]   = 1'b1;
      end
    end
  end

  always_ff @(posedge ilaunch_clk) begin
    if (!tx_irstb) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_en_q   <= 1'b0;
      req_lane_q <= '0;
      map_en_q   <= 1'b0;
      map_lane_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      prbs_q     <= PRBS_SEED;
      pat_q      <= 2'b00;
      clk_tgl_q  <= 1'b0;
      odat0_q    <= '0;
      odat1_q    <= '0;
      otxen_q    <= '0;
      eng_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_en_q   <= req_en_d;
      req_lane_q <= req_lane_d;
      map_en_q   <= map_en_d;
      map_lane_q <= map_lane_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      prbs_q     <= prbs_d;
      pat_q      <= pat_d;
      clk_tgl_q  <= clk_tgl_d;
      odat0_q    <= odat0_d;
      odat1_q    <= odat1_d;
      otxen_q    <= otxen_d;
      eng_q      <= eng_d;
    end
  end

  assign odat0        = odat0_q;
  assign odat1        = odat1_q;
  assign otxen        = otxen_q;
  assign oredn_engage = eng_q;
  assign redn_busy    = (state_q != S_IDLE);
  assign redn_ack     = ack_q;
  assign redn_err     = err_q;

endmodule

// File: tb/tb_itrx_aib_phy_tx_lane_redn.sv
// Directed bench for itrx_aib_phy_tx_lane_redn: a cycle model pushes expected outputs
// into a queue before each edge, which are popped and compared after the edge.
module tb_itrx_aib_phy_tx_lane_redn;

  localparam int NLANE = 20;
  localparam int QUIET = 8;
  localparam int LW    = 5;
  localparam int PW    = NLANE + 1;
  localparam int OW    = 4 * PW + 3;
  localparam logic [NLANE-1:0] EVEN = 20'h55555;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstb;
  logic             ddr;
  logic [NLANE-1:0] idat0, idat1;
  logic [1:0]       pat;
  logic             req, en;
  logic [LW-1:0]    lane;
  logic [PW-1:0]    odat0, odat1, otxen, oredn_engage;
  logic             redn_busy, redn_ack, redn_err;

  itrx_aib_phy_tx_lane_redn #(.NLANE(NLANE), .QUIET(QUIET)) dut (
    .ilaunch_clk (clk),
    .tx_irstb    (rstb),
    .iddr_enable (ddr),
    .idat0       (idat0),
    .idat1       (idat1),
    .pat_mode    (pat),
    .redn_req    (req),
    .redn_en     (en),
    .redn_lane   (lane),
    .odat0       (odat0),
    .odat1       (odat1),
    .otxen       (otxen),
    .oredn_engage(oredn_engage),
    .redn_busy   (redn_busy),
    .redn_ack    (redn_ack),
    .redn_err    (redn_err)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // reference model state
  logic       prbs_ref [0:126];
  int         seq = -1;
  logic       m_rep = 1'b0, n_rep = 1'b0;
  logic [LW-1:0] m_lane = '0, n_lane = '0;
  int         pn = 0;
  logic [1:0] m_prev = 2'b00;
  logic       sdr_clk_prev = 1'b0, sdr_clk_last = 1'b0;

  function automatic logic [PW-1:0] map_data(input logic [NLANE-1:0] l, input logic rep,
                                             input logic [LW-1:0] f);
    logic [PW-1:0] x;
    x = {1'b0, l};
    if (!rep) return x;
    return (x & ((PW'(1) << f) - PW'(1))) | ((x >> f) << (f + 1));
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] a, input logic [PW-1:0] e);
    checks++;
    assert (a === e) passed++;
    else $error("FAIL %s got %h want %h", tag, a, e);
  endtask

  task automatic check_bit(input string tag, input logic a, input logic e);
    checks++;
    assert (a === e) passed++;
    else $error("FAIL %s got %b want %b", tag, a, e);
  endtask

  // one clock edge: predict, push, advance, pop, compare
  task automatic cycle(input string tag);
    logic [PW-1:0]    d0, d1, tx, eg;
    logic             bz, ak, er, pre_busy, b0, b1, cb;
    logic [NLANE-1:0] l0, l1;
    logic [OW-1:0]    e, a;
    d0 = '0; d1 = '0; tx = '0; eg = '0; bz = 1'b0; ak = 1'b0; er = 1'b0;
    l0 = '0; l1 = '0;
    if (!rstb) begin
      seq = -1; m_rep = 1'b0; m_lane = '0; pn = 0; m_prev = 2'b00;
      sdr_clk_prev = 1'b0; sdr_clk_last = 1'b0;
    end else begin
      pre_busy = (seq >= 0);
      if (seq >= 0) begin
        if (seq == QUIET) begin m_rep = n_rep; m_lane = n_lane; end
        if (seq == 2 * QUIET) begin seq = -1; ak = 1'b1; end
        else seq++;
      end else if (req) begin
        if (en && (lane >= LW'(NLANE))) begin ak = 1'b1; er = 1'b1; end
        else begin seq = 0; n_rep = en; n_lane = lane; end
      end
      bz = (seq >= 0);
      case (pat)
        2'b00: begin l0 = idat0; l1 = ddr ? idat1 : idat0; end
        2'b01: begin
          if (m_prev != 2'b01) pn = 0;
          b0 = prbs_ref[pn];
          if (ddr) begin b1 = prbs_ref[(pn + 1) % 127]; pn = (pn + 2) % 127; end
          else     begin b1 = b0;                      pn = (pn + 1) % 127; end
          l0 = b0 ? EVEN : ~EVEN;
          l1 = b1 ? EVEN : ~EVEN;
        end
        2'b10: begin
          if (ddr) begin l0 = '1; l1 = '0; end
          else begin
            cb = sdr_clk_prev ? ~sdr_clk_last : 1'b1;
            sdr_clk_last = cb;
            l0 = {NLANE{cb}}; l1 = {NLANE{cb}};
          end
        end
        default: ;
      endcase
      sdr_clk_prev = (pat == 2'b10) && !ddr;
      m_prev = pat;
      if (pre_busy) begin l0 = '0; l1 = '0; end
      d0 = map_data(l0, m_rep, m_lane);
      d1 = map_data(l1, m_rep, m_lane);
      tx = m_rep ? ~(PW'(1) << m_lane) : {1'b0, {NLANE{1'b1}}};
      eg = m_rep ? ~((PW'(1) << m_lane) - PW'(1)) : '0;
    end
    exp_q.push_back({d0, d1, tx, eg, bz, ak, er});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {odat0, odat1, otxen, oredn_engage, redn_busy, redn_ack, redn_err};
    checks++;
    assert (a === e) passed++;
    else $error("FAIL %s got %h want %h (d0,d1,txen,eng,busy,ack,err)", tag, a, e);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      idat0 = NLANE'($urandom());
      idat1 = NLANE'($urandom());
      if (pat == 2'b00 && $urandom_range(0, 7) == 0) ddr = ~ddr;
      cycle(tag);
    end
  endtask

  task automatic request(input logic r_en, input logic [LW-1:0] r_lane, input string tag);
    req = 1'b1; en = r_en; lane = r_lane;
    cycle(tag);
    req = 1'b0; en = 1'b0; lane = '0;
  endtask

  initial begin
    for (int i = 0; i < 7; i++) prbs_ref[i] = 1'b1;
    for (int n = 0; n < 120; n++) prbs_ref[n + 7] = prbs_ref[n] ^ prbs_ref[n + 1];

    rstb = 1'b0; ddr = 1'b1; idat0 = '0; idat1 = '0; pat = 2'b00;
    req = 1'b0; en = 1'b0; lane = '0;
    repeat (3) cycle("reset");
    check("reset_otxen", otxen, '0);

    // T1: plain DDR mapping
    rstb = 1'b1; idat0 = 20'hA5A5A; idat1 = ~20'hA5A5A;
    cycle("t1");
    check("t1_odat0", odat0, 21'h0A5A5A);
    check("t1_odat1", odat1, 21'h05A5A5);
    check("t1_otxen", otxen, 21'h0FFFFF);
    run(10, "t1_rand");

    // T2: repair lane 5
    ddr = 1'b1;
    request(1'b1, 5'd5, "t2_req");
    check_bit("t2_busy", redn_busy, 1'b1);
    run(16, "t2_seq");
    ddr = 1'b1; idat0 = 20'hA5A5A; idat1 = ~20'hA5A5A;
    cycle("t2_last");
    check_bit("t2_ack", redn_ack, 1'b1);
    cycle("t2_map");
    check("t2_odat0", odat0, 21'h14B49A);
    check("t2_odat1", odat1, 21'h0B4B45);
    check("t2_otxen", otxen, 21'h1FFFDF);
    check("t2_engage", oredn_engage, 21'h1FFFE0);

    // T3: out-of-range lane rejected; request during DRAIN ignored
    request(1'b1, 5'd20, "t3_bad");
    check_bit("t3_ack", redn_ack, 1'b1);
    check_bit("t3_err", redn_err, 1'b1);
    check_bit("t3_busy", redn_busy, 1'b0);
    request(1'b1, 5'd3, "t3_req");
    run(3, "t3_drain");
    request(1'b1, 5'd7, "t3_ign");
    run(16, "t3_seq");
    check("t3_otxen", otxen, 21'h1FFFF7);
    request(1'b0, 5'd0, "t3_clr");
    run(18, "t3_clr_seq");
    check("t3_clr_otxen", otxen, 21'h0FFFFF);
    request(1'b0, 5'd0, "t3_same");
    run(18, "t3_same_seq");

    // T4: PRBS7 DDR from reset, then SDR, then re-entry
    rstb = 1'b0; cycle("t4_rst");
    rstb = 1'b1; pat = 2'b01; ddr = 1'b1;
    repeat (70) cycle("t4_ddr");
    ddr = 1'b0;
    repeat (140) cycle("t4_sdr");
    pat = 2'b00; cycle("t4_norm");
    pat = 2'b01; ddr = 1'b1;
    repeat (10) cycle("t4_reseed");
    pat = 2'b00;

    // T5: reset during SETTLE, then a clean request
    request(1'b1, 5'd10, "t5_req");
    run(12, "t5_seq");
    rstb = 1'b0; cycle("t5_rst");
    check("t5_odat0", odat0, '0);
    check_bit("t5_ack", redn_ack, 1'b0);
    rstb = 1'b1;
    run(3, "t5_idle");
    check("t5_otxen", otxen, 21'h0FFFFF);
    request(1'b1, 5'd2, "t5_req2");
    run(18, "t5_seq2");
    check("t5_engage", oredn_engage, 21'h1FFFFC);

    // T6: clock pattern and forced zero around failed lane 2
    pat = 2'b10; ddr = 1'b1;
    repeat (3) cycle("t6_ddr");
    check("t6_odat0", odat0, 21'h1FFFFB);
    check("t6_odat1", odat1, '0);
    ddr = 1'b0;
    repeat (6) cycle("t6_sdr");
    pat = 2'b11;
    repeat (3) cycle("t6_zero");
    check("t6_zero_d0", odat0, '0);
    check("t6_zero_tx", otxen, 21'h1FFFFB);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
